// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse position decoder.
// Status-byte bit positions follow the standard 3-byte PS/2 mouse packet layout.
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    UPDATE
  } state_t;

  localparam int POS_W = 12;
  localparam int SUM_W = 14;

  localparam int ST_LEFT   = 0;
  localparam int ST_RIGHT  = 1;
  localparam int ST_MIDDLE = 2;
  localparam int ST_SYNC   = 3;
  localparam int ST_XSIGN  = 4;
  localparam int ST_YSIGN  = 5;
  localparam int ST_XOVF   = 6;
  localparam int ST_YOVF   = 7;

endpackage

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: applies a 9-bit signed delta (zeroed on overflow), then clamps to 0..MAX.
// Purely combinational; the caller registers the result.
module mouse_axis_clamp
  import mouse_pkg::*;
#(
  parameter int MAX      = 1023,
  parameter bit SUBTRACT = 1'b0
) (
  input  logic [POS_W-1:0] i_pos,
  input  logic             i_sign,
  input  logic [7:0]       i_low,
  input  logic             i_ovf,
  output logic [POS_W-1:0] o_pos
);

  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX);
  localparam logic        [POS_W-1:0] MAX_U = POS_W'(MAX);

  logic signed [SUM_W-1:0] w_pos;
  logic signed [SUM_W-1:0] w_delta;
  logic signed [SUM_W-1:0] w_sum;

  assign w_pos   = $signed({{(SUM_W-POS_W){1'b0}}, i_pos});
  assign w_delta = i_ovf ? '0 : $signed({{(SUM_W-9){i_sign}}, i_sign, i_low});
  assign w_sum   = SUBTRACT ? (w_pos - w_delta) : (w_pos + w_delta);

  // Screen Y grows downward while mouse Y grows upward, hence the subtracting mode.
  always_comb begin
    if (w_sum[SUM_W-1]) begin
      o_pos = '0;
    end else if (w_sum > MAX_S) begin
      o_pos = MAX_U;
    end else begin
      o_pos = w_sum[POS_W-1:0];
    end
  end

endmodule

// File: rtl/mouse_pos_decoder.sv
// Decodes 3-byte PS/2 mouse packets into a clamped cursor position and button state.
// Outputs update two cycles after the last packet byte is accepted; bad sync or idle timeout pulses pkt_err.
module mouse_pos_decoder
  import mouse_pkg::*;
#(
  parameter int X_MAX   = 1023,
  parameter int Y_MAX   = 767,
  parameter int X_INIT  = 512,
  parameter int Y_INIT  = 384,
  parameter int TIMEOUT = 65000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_middle,
  output logic        pos_valid,
  output logic        pkt_err
);

  localparam int                 IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]        r_status;
  logic [7:0]        r_dx_lo;
  logic [7:0]        r_dy_lo;
  logic [IDLE_W-1:0] r_idle;
  logic [POS_W-1:0]  r_xpos;
  logic [POS_W-1:0]  r_ypos;
  logic [2:0]        r_btn;
  logic              r_pos_valid;
  logic              r_pkt_err;

  logic [POS_W-1:0]  w_new_x;
  logic [POS_W-1:0]  w_new_y;
  logic              w_ld_status;
  logic              w_ld_dx;
  logic              w_ld_dy;
  logic              w_idle_inc;
  logic              w_err;
  logic              w_update;
  logic              w_unused_sync;

  // The sync bit is only inspected on arrival; the latched copy is always 1.
  assign w_unused_sync = r_status[ST_SYNC];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_B0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_status = 1'b0;
    w_ld_dx     = 1'b0;
    w_ld_dy     = 1'b0;
    w_idle_inc  = 1'b0;
    w_err       = 1'b0;
    w_update    = 1'b0;
    case (r_state)
      // UPDATE also listens for a new status byte so back-to-back packets lose nothing.
      WAIT_B0, UPDATE: begin
        w_update    = (r_state == UPDATE);
        w_state_nxt = WAIT_B0;
        if (rx_valid) begin
          if (rx_data[ST_SYNC]) begin
            w_ld_status = 1'b1;
            w_state_nxt = WAIT_B1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      WAIT_B1: begin
        if (rx_valid) begin
          w_ld_dx     = 1'b1;
          w_state_nxt = WAIT_B2;
        end else if (r_idle == IDLE_LAST) begin
          w_err       = 1'b1;
          w_state_nxt = WAIT_B0;
        end else begin
          w_idle_inc = 1'b1;
        end
      end
      WAIT_B2: begin
        if (rx_valid) begin
          w_ld_dy     = 1'b1;
          w_state_nxt = UPDATE;
        end else if (r_idle == IDLE_LAST) begin
          w_err       = 1'b1;
          w_state_nxt = WAIT_B0;
        end else begin
          w_idle_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = WAIT_B0;
      end
    endcase
  end

  mouse_axis_clamp #(
    .MAX      (X_MAX),
    .SUBTRACT (1'b0)
  ) u_clamp_x (
    .i_pos  (r_xpos),
    .i_sign (r_status[ST_XSIGN]),
    .i_low  (r_dx_lo),
    .i_ovf  (r_status[ST_XOVF]),
    .o_pos  (w_new_x)
  );

  mouse_axis_clamp #(
    .MAX      (Y_MAX),
    .SUBTRACT (1'b1)
  ) u_clamp_y (
    .i_pos  (r_ypos),
    .i_sign (r_status[ST_YSIGN]),
    .i_low  (r_dy_lo),
    .i_ovf  (r_status[ST_YOVF]),
    .o_pos  (w_new_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status    <= '0;
      r_dx_lo     <= '0;
      r_dy_lo     <= '0;
      r_idle      <= '0;
      r_xpos      <= POS_W'(X_INIT);
      r_ypos      <= POS_W'(Y_INIT);
      r_btn       <= '0;
      r_pos_valid <= 1'b0;
      r_pkt_err   <= 1'b0;
    end else begin
      if (w_ld_status) r_status <= rx_data;
      if (w_ld_dx)     r_dx_lo  <= rx_data;
      if (w_ld_dy)     r_dy_lo  <= rx_data;
      r_idle      <= w_idle_inc ? r_idle + 1'b1 : '0;
      r_pos_valid <= w_update;
      r_pkt_err   <= w_err;
      if (w_update) begin
        r_xpos <= w_new_x;
        r_ypos <= w_new_y;
        r_btn  <= {r_status[ST_MIDDLE], r_status[ST_RIGHT], r_status[ST_LEFT]};
      end
    end
  end

  assign xpos       = r_xpos;
  assign ypos       = r_ypos;
  assign btn_left   = r_btn[0];
  assign btn_right  = r_btn[1];
  assign btn_middle = r_btn[2];
  assign pos_valid  = r_pos_valid;
  assign pkt_err    = r_pkt_err;

endmodule

// File: tb/tb_mouse_pos_decoder.sv
// Scoreboard bench for mouse_pos_decoder: packets push expected positions, pos_valid pops them.
module tb_mouse_pos_decoder;

  localparam int X_MAX  = 1023;
  localparam int Y_MAX  = 767;
  localparam int X_INIT = 512;
  localparam int Y_INIT = 384;
  localparam int TO     = 200;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        btn_left;
  logic        btn_right;
  logic        btn_middle;
  logic        pos_valid;
  logic        pkt_err;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  btn;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   checks   = 0;
  int   failures = 0;
  int   mx       = X_INIT;
  int   my       = Y_INIT;

  mouse_pos_decoder #(
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX),
    .X_INIT  (X_INIT),
    .Y_INIT  (Y_INIT),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .xpos       (xpos),
    .ypos       (ypos),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_middle (btn_middle),
    .pos_valid  (pos_valid),
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int   dx;
    int   dy;
    exp_t e;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    mx = clampi(mx + dx, X_MAX);
    my = clampi(my - dy, Y_MAX);
    e.x   = 12'(mx);
    e.y   = 12'(my);
    e.btn = b0[2:0];
    exp_q.push_back(e);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    push_pkt(b0, b1, b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    mx  = X_INIT;
    my  = Y_INIT;
  endtask

  // Scoreboard: every pos_valid pulse must match the oldest expected update.
  always @(posedge clk) begin
    #1;
    if (pos_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_update: got x=%0d y=%0d, expected no pos_valid", xpos, ypos);
      end else begin
        e_mon = exp_q.pop_front();
        if ({xpos, ypos, btn_middle, btn_right, btn_left} !== {e_mon.x, e_mon.y, e_mon.btn}) begin
          failures++;
          $display("FAIL sb_update: got x=%0d y=%0d btn=%b, expected x=%0d y=%0d btn=%b",
                   xpos, ypos, {btn_middle, btn_right, btn_left}, e_mon.x, e_mon.y, e_mon.btn);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (xpos !== 12'd512) begin failures++; $display("FAIL reset_xpos: got %0d expected 512", xpos); end
    checks++;
    if (ypos !== 12'd384) begin failures++; $display("FAIL reset_ypos: got %0d expected 384", ypos); end
    checks++;
    if ({btn_middle, btn_right, btn_left} !== 3'b000) begin
      failures++; $display("FAIL reset_btn: got %b expected 000", {btn_middle, btn_right, btn_left});
    end
    checks++;
    if ({pos_valid, pkt_err} !== 2'b00) begin
      failures++; $display("FAIL reset_pulses: got pos_valid=%b pkt_err=%b expected 0 0", pos_valid, pkt_err);
    end
    rst = 1'b0;
    mx  = X_INIT;
    my  = Y_INIT;
  endtask

  task automatic test_basic();
    send_pkt(8'h08, 8'h0A, 8'h05);
    checks++;
    if (pos_valid !== 1'b0) begin failures++; $display("FAIL basic_early: pos_valid=%b at N+1, expected 0", pos_valid); end
    tick();
    checks++;
    if ({pos_valid, xpos, ypos} !== {1'b1, 12'd522, 12'd379}) begin
      failures++;
      $display("FAIL basic_n2: got pv=%b x=%0d y=%0d, expected pv=1 x=522 y=379", pos_valid, xpos, ypos);
    end
    tick();
    checks++;
    if (pos_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width: pos_valid=%b at N+3, expected 0", pos_valid); end
    idle(2);
  endtask

  task automatic test_clamp();
    do_reset();
    for (int i = 0; i < 3; i++) begin send_pkt(8'h19, 8'h00, 8'h00); idle(2); end
    checks++;
    if ({xpos, btn_left} !== {12'd0, 1'b1}) begin
      failures++; $display("FAIL clamp_x_low: got x=%0d left=%b expected x=0 left=1", xpos, btn_left);
    end
    for (int i = 0; i < 5; i++) begin send_pkt(8'h08, 8'hFF, 8'h00); idle(2); end
    checks++;
    if (xpos !== 12'd1023) begin failures++; $display("FAIL clamp_x_high: got %0d expected 1023", xpos); end
    for (int i = 0; i < 2; i++) begin send_pkt(8'h28, 8'h00, 8'h00); idle(2); end
    checks++;
    if (ypos !== 12'd767) begin failures++; $display("FAIL clamp_y_high: got %0d expected 767", ypos); end
    for (int i = 0; i < 7; i++) begin send_pkt(8'h08, 8'h00, 8'h7F); idle(2); end
    checks++;
    if (ypos !== 12'd0) begin failures++; $display("FAIL clamp_y_low: got %0d expected 0", ypos); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_pkt(8'h48, 8'h7F, 8'h10);
    tick();
    checks++;
    if ({pos_valid, xpos, ypos} !== {1'b1, 12'd512, 12'd368}) begin
      failures++;
      $display("FAIL x_overflow: got pv=%b x=%0d y=%0d, expected pv=1 x=512 y=368", pos_valid, xpos, ypos);
    end
    idle(2);
    send_pkt(8'h8E, 8'h05, 8'h7F);
    idle(2);
    checks++;
    if ({xpos, ypos, btn_middle, btn_right, btn_left} !== {12'd517, 12'd368, 3'b110}) begin
      failures++;
      $display("FAIL y_overflow: got x=%0d y=%0d btn=%b, expected x=517 y=368 btn=110",
               xpos, ypos, {btn_middle, btn_right, btn_left});
    end
  endtask

  task automatic test_sync_err();
    send_byte(8'h00);
    checks++;
    if ({pkt_err, pos_valid, xpos} !== {1'b1, 1'b0, 12'd517}) begin
      failures++;
      $display("FAIL sync_err: got err=%b pv=%b x=%0d, expected err=1 pv=0 x=517", pkt_err, pos_valid, xpos);
    end
    tick();
    checks++;
    if (pkt_err !== 1'b0) begin failures++; $display("FAIL sync_err_width: pkt_err=%b expected 0", pkt_err); end
    send_pkt(8'h08, 8'h01, 8'h01);
    idle(2);
    checks++;
    if ({xpos, ypos} !== {12'd518, 12'd367}) begin
      failures++; $display("FAIL sync_recover: got x=%0d y=%0d expected x=518 y=367", xpos, ypos);
    end
  endtask

  task automatic test_timeout();
    logic err_seen;
    do_reset();
    send_byte(8'h08);
    send_byte(8'h05);
    err_seen = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      if (pkt_err !== 1'b0) err_seen = 1'b1;
    end
    checks++;
    if (err_seen !== 1'b0) begin failures++; $display("FAIL timeout_early: pkt_err seen before %0d idle cycles, expected none", TO); end
    tick();
    checks++;
    if ({pkt_err, pos_valid, xpos, ypos} !== {1'b1, 1'b0, 12'd512, 12'd384}) begin
      failures++;
      $display("FAIL timeout_fire: got err=%b pv=%b x=%0d y=%0d, expected err=1 pv=0 x=512 y=384",
               pkt_err, pos_valid, xpos, ypos);
    end
    send_pkt(8'h08, 8'h01, 8'h01);
    tick();
    checks++;
    if ({pos_valid, xpos, ypos} !== {1'b1, 12'd513, 12'd383}) begin
      failures++;
      $display("FAIL timeout_recover: got pv=%b x=%0d y=%0d, expected pv=1 x=513 y=383", pos_valid, xpos, ypos);
    end
    idle(2);
  endtask

  task automatic test_timeout_race();
    push_pkt(8'h08, 8'h03, 8'h02);
    send_byte(8'h08);
    idle(TO - 1);
    send_byte(8'h03);
    checks++;
    if (pkt_err !== 1'b0) begin failures++; $display("FAIL timeout_race_err: pkt_err=%b expected 0", pkt_err); end
    send_byte(8'h02);
    tick();
    checks++;
    if ({pos_valid, xpos, ypos} !== {1'b1, 12'd516, 12'd381}) begin
      failures++;
      $display("FAIL timeout_race_update: got pv=%b x=%0d y=%0d, expected pv=1 x=516 y=381", pos_valid, xpos, ypos);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    push_pkt(8'h08, 8'h02, 8'h02);
    push_pkt(8'h09, 8'h01, 8'h01);
    send_byte(8'h08); send_byte(8'h02); send_byte(8'h02);
    send_byte(8'h09); send_byte(8'h01); send_byte(8'h01);
    tick();
    checks++;
    if ({pos_valid, xpos, ypos, btn_left} !== {1'b1, 12'd519, 12'd378, 1'b1}) begin
      failures++;
      $display("FAIL back_to_back: got pv=%b x=%0d y=%0d left=%b, expected pv=1 x=519 y=378 left=1",
               pos_valid, xpos, ypos, btn_left);
    end
    idle(2);
    push_pkt(8'h08, 8'h01, 8'h01);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    checks++;
    if ({pos_valid, pkt_err, xpos, ypos} !== {1'b1, 1'b1, 12'd520, 12'd377}) begin
      failures++;
      $display("FAIL bad_byte_in_update: got pv=%b err=%b x=%0d y=%0d, expected pv=1 err=1 x=520 y=377",
               pos_valid, pkt_err, xpos, ypos);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic pv_seen;
    send_byte(8'h08);
    send_byte(8'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mx  = X_INIT;
    my  = Y_INIT;
    checks++;
    if ({xpos, ypos} !== {12'd512, 12'd384}) begin
      failures++; $display("FAIL reset_mid_pos: got x=%0d y=%0d expected x=512 y=384", xpos, ypos);
    end
    send_byte(8'h05);
    checks++;
    if (pkt_err !== 1'b1) begin failures++; $display("FAIL reset_mid_resync: pkt_err=%b expected 1", pkt_err); end
    pv_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (pos_valid !== 1'b0) pv_seen = 1'b1;
      tick();
    end
    checks++;
    if (pv_seen !== 1'b0) begin failures++; $display("FAIL reset_mid_no_update: pos_valid seen, expected none"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_overflow();
    test_sync_err();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover: %0d expected updates never seen, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mouse_pos_decoder.md
MOUSE_POS_DECODER -- requirements
Module: mouse_pos_decoder

Interface
REQ-001 Parameter: X_MAX, 1023, largest legal xpos value.
REQ-002 Parameter: Y_MAX, 767, largest legal ypos value.
REQ-003 Parameter: X_INIT, 512, xpos after reset.
REQ-004 Parameter: Y_INIT, 384, ypos after reset.
REQ-005 Parameter: TIMEOUT, 65000, maximum idle clk cycles allowed between bytes of one packet.
REQ-006 Port: clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-007 Port: rst  input  1  reset, synchronous, active-high.
REQ-008 Port: rx_data  input  8  received PS/2 mouse byte.
REQ-009 Port: rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-010 Port: xpos  output  12  cursor X, unsigned, range 0..X_MAX.
REQ-011 Port: ypos  output  12  cursor Y, unsigned, screen-down positive, range 0..Y_MAX.
REQ-012 Port: btn_left, btn_right, btn_middle  output  1 each  button state from last good packet.
REQ-013 Port: pos_valid  output  1  one-cycle pulse when outputs update.
REQ-014 Port: pkt_err  output  1  one-cycle pulse on sync error or timeout.

Function
REQ-015 FSM states SHALL be: WAIT_B0, WAIT_B1, WAIT_B2, UPDATE.
REQ-016 In WAIT_B0, a byte with rx_data[3]=1 SHALL be latched as status byte and the FSM SHALL go to WAIT_B1.
REQ-017 In WAIT_B0, a byte with rx_data[3]=0 SHALL be discarded, pkt_err SHALL pulse next cycle, and the FSM SHALL stay in WAIT_B0.
REQ-018 In WAIT_B1 and WAIT_B2, the byte SHALL be latched as the X and Y delta low byte respectively, and the FSM SHALL advance.
REQ-019 Status byte mapping: bit0 left, bit1 right, bit2 middle, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-020 Deltas: each delta SHALL be a 9-bit two's-complement value {sign, low byte}.
REQ-021 If an axis overflow bit is set, that axis delta SHALL be treated as 0; buttons SHALL still update.
REQ-022 UPDATE SHALL compute new_x = xpos + dx and new_y = ypos - dy as signed 14-bit values, clamped to 0..X_MAX and 0..Y_MAX.
REQ-023 UPDATE SHALL last exactly one cycle and then return to WAIT_B0.
REQ-024 Latency: if byte 2 is accepted in cycle N, then xpos, ypos and the buttons SHALL show new values, with pos_valid=1, in cycle N+2 only.
REQ-025 An rx_valid arriving during UPDATE SHALL be handled as a WAIT_B0 byte, so no byte is lost.
REQ-026 An idle counter SHALL reset on every accepted byte and count in WAIT_B1 and WAIT_B2.
REQ-027 When the idle counter reaches TIMEOUT, the FSM SHALL go to WAIT_B0, pulse pkt_err, and discard the partial packet.
REQ-028 If rx_valid arrives in the same cycle the timeout expires, the byte SHALL be accepted and the timeout ignored.
REQ-029 Outputs SHALL hold between updates; a discarded packet SHALL NOT change any output.

Reset
REQ-030 On rst: FSM=WAIT_B0, xpos=X_INIT, ypos=Y_INIT, all buttons=0, pos_valid=0, pkt_err=0, idle counter=0, latched bytes=0.
REQ-031 rst asserted mid-packet SHALL abandon the packet, and no pos_valid SHALL follow.

Structure
REQ-032 The state enum and status-byte bit indices SHALL be defined in the shared package mouse_pkg.
REQ-033 One sub-module, mouse_axis_clamp, SHALL perform the add, clamp and overflow masking for one axis, instantiated twice, with Y instantiated in subtracting mode.
REQ-034 All outputs SHALL be registered; there SHALL be no combinational path from rx_data to any output.

Verification
REQ-035 Reset, then bytes 0x08, 0x0A, 0x05 -> in cycle N+2: xpos=522, ypos=379, buttons 0, pos_valid one cycle.
REQ-036 From reset, bytes 0x19, 0x00, 0x00 (dx=-256) three times -> xpos=0 after the third packet (clamped), btn_left=1.
REQ-037 Bytes 0x48, 0x7F, 0x10 (X overflow) -> xpos unchanged, ypos=Y_INIT-16, pos_valid pulses.
REQ-038 Byte 0x00 in WAIT_B0 -> pkt_err pulse, no state change; following valid packet decodes correctly.
REQ-039 Bytes 0x08, 0x05, then TIMEOUT idle cycles -> pkt_err pulse, outputs unchanged; next 0x08,0x01,0x01 gives xpos=X_INIT+1, ypos=Y_INIT-1.
REQ-040 rst asserted after byte 1 -> no pos_valid; xpos/ypos return to X_INIT/Y_INIT next cycle.
